// File: rtl/hazard_control_unit.sv
// ---------------------------------------------------------------------------
// hazard_control_unit
//
// Pipeline sequencing controller for the 16-bit, 16-register pipelined CPU.
// It decides each cycle whether the pipeline advances, stalls, bubbles or
// flushes. The causes it handles are:
//   - load-use hazards and branch-operand dependencies,
//   - the multi-cycle occupancy of EX by the shared mul/div unit,
//   - taken-branch flushes of IF/ID,
//   - HALT.
//
// Ports
//   clk, rst          : clock; asynchronous active-high reset
//   id_op1, id_op2    : source register ids of the instruction in ID
//   id_branch         : ID instruction is a branch comparing id_op1
//   id_halt           : ID instruction is HALT
//   branch_taken      : branch in ID resolved taken
//   ex_op1            : destination register id of the instruction in EX
//   ex_regwrite       : EX write-back type (2'b00 = no write)
//   ex_memread        : EX instruction is a load
//   ex_muldiv         : EX instruction is multiply/divide
//   pc_write          : PC update enable
//   ifid_write        : IF/ID load enable
//   ifid_flush        : clear IF/ID to NOP
//   idex_write        : ID/EX load enable
//   idex_bubble       : load NOP into ID/EX
//   exmem_bubble      : load NOP into EX/MEM
//   muldiv_start      : one-cycle start strobe to the mul/div unit
//   muldiv_busy       : mul/div sequence in progress
//   halted            : processor halted
//
// Handshake note: there is no valid/ready pairing here. Every output is a
// level-sensitive enable, valid in the cycle it is asserted, and it is
// computed combinationally from the current state and the current inputs.
// ---------------------------------------------------------------------------
module hazard_control_unit #(
    parameter int MULDIV_CYCLES = 8,
    parameter int REG_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_op1,
    input  logic [REG_W-1:0] id_op2,
    input  logic             id_branch,
    input  logic             id_halt,
    input  logic             branch_taken,
    input  logic [REG_W-1:0] ex_op1,
    input  logic [1:0]       ex_regwrite,
    input  logic             ex_memread,
    input  logic             ex_muldiv,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_bubble,
    output logic             muldiv_start,
    output logic             muldiv_busy,
    output logic             halted
);

    localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MULDIV = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic load_use;
    logic branch_dep;

    assign load_use   = ex_memread & ((ex_op1 == id_op1) | (ex_op1 == id_op2));
    assign branch_dep = id_branch & (ex_regwrite != 2'b00) & (ex_op1 == id_op1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // Default is a normal advance with no bubbles.
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        muldiv_start = 1'b0;
        muldiv_busy  = 1'b0;
        halted       = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;

        case (state_q)
            ST_RUN: begin
                if (ex_muldiv) begin
                    // The start cycle is the first frozen cycle, so the
                    // remaining count is MULDIV_CYCLES-1.
                    muldiv_start = 1'b1;
                    muldiv_busy  = 1'b1;
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_bubble = 1'b1;
                    cnt_d        = CNT_LOAD;
                    state_d      = ST_MULDIV;
                end else if (load_use || branch_dep) begin
                    // Stall wins over halt and taken branch, so a flush
                    // never coincides with a stall.
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end else if (id_halt) begin
                    // HALT itself moves on into ID/EX; fetch stops.
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    state_d    = ST_HALT;
                end else if (branch_taken) begin
                    ifid_flush = 1'b1;
                end
            end

            ST_MULDIV: begin
                muldiv_busy  = 1'b1;
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_write   = 1'b0;
                exmem_bubble = 1'b1;
                // Saturate at zero so a corrupted count cannot wrap.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_RUN;
                end
            end

            ST_HALT: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_write  = 1'b0;
                idex_bubble = 1'b1;
                halted      = 1'b1;
            end

            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

endmodule
